// File: rtl/cpu_move_engine_if.sv
// Board-port and controller handshake bundle for the CPU move engine.
// master = the engine, slave = controller / board store side.
interface cpu_move_engine_if;
  logic       clr;
  logic       cpu_input_en;
  logic [3:0] rd_addr;
  logic [1:0] rd_data;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [1:0] wr_data;
  logic       cpu_done;
  logic       no_move;
  logic       busy;

  modport master (
    input  clr, cpu_input_en, rd_data,
    output rd_addr, wr_en, wr_addr, wr_data, cpu_done, no_move, busy
  );

  modport slave (
    output clr, cpu_input_en, rd_data,
    input  rd_addr, wr_en, wr_addr, wr_data, cpu_done, no_move, busy
  );
endinterface

// File: rtl/cpu_move_engine.sv
// Tic-tac-toe CPU move engine: snapshots the board, scans the 8 lines for a
// win or block, picks a cell by fixed priority and writes one CPU mark.
module cpu_move_engine #(
  parameter logic [1:0] EMPTY_CODE  = 2'b00,
  parameter logic [1:0] PLAYER_CODE = 2'b01,
  parameter logic [1:0] CPU_CODE    = 2'b10
) (
  input logic               clk,
  input logic               rst,
  cpu_move_engine_if.master bus
);

  typedef enum logic [2:0] {
    StIdle, StLoad, StEval, StPick, StWrite, StDone, StWaitLow
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] snap_q [9];
  logic       win_vld_q, blk_vld_q, no_move_q, no_move_d;
  logic [3:0] win_cell_q, blk_cell_q, pick_q, pick_d;
  logic [3:0] line_cell [3];
  logic [3:0] line_empty;
  logic [1:0] n_cpu, n_player, n_empty;

  // Line order during EVAL: rows, columns, diagonals.
  always_comb begin
    unique case (cnt_q[2:0])
      3'd0: line_cell = '{4'd0, 4'd1, 4'd2};
      3'd1: line_cell = '{4'd3, 4'd4, 4'd5};
      3'd2: line_cell = '{4'd6, 4'd7, 4'd8};
      3'd3: line_cell = '{4'd0, 4'd3, 4'd6};
      3'd4: line_cell = '{4'd1, 4'd4, 4'd7};
      3'd5: line_cell = '{4'd2, 4'd5, 4'd8};
      3'd6: line_cell = '{4'd0, 4'd4, 4'd8};
      3'd7: line_cell = '{4'd2, 4'd4, 4'd6};
    endcase
  end

  // Code 2'b11 falls through every test, so it is neither empty nor marked.
  always_comb begin
    n_cpu      = '0;
    n_player   = '0;
    n_empty    = '0;
    line_empty = '0;
    for (int i = 0; i < 3; i++) begin
      if (snap_q[line_cell[i]] == CPU_CODE) begin
        n_cpu = n_cpu + 2'd1;
      end else if (snap_q[line_cell[i]] == PLAYER_CODE) begin
        n_player = n_player + 2'd1;
      end else if (snap_q[line_cell[i]] == EMPTY_CODE) begin
        n_empty    = n_empty + 2'd1;
        line_empty = line_cell[i];
      end
    end
  end

  always_comb begin
    pick_d    = '0;
    no_move_d = 1'b0;
    if (win_vld_q)                      pick_d = win_cell_q;
    else if (blk_vld_q)                 pick_d = blk_cell_q;
    else if (snap_q[4] == EMPTY_CODE)   pick_d = 4'd4;
    else if (snap_q[0] == EMPTY_CODE)   pick_d = 4'd0;
    else if (snap_q[2] == EMPTY_CODE)   pick_d = 4'd2;
    else if (snap_q[6] == EMPTY_CODE)   pick_d = 4'd6;
    else if (snap_q[8] == EMPTY_CODE)   pick_d = 4'd8;
    else if (snap_q[1] == EMPTY_CODE)   pick_d = 4'd1;
    else if (snap_q[3] == EMPTY_CODE)   pick_d = 4'd3;
    else if (snap_q[5] == EMPTY_CODE)   pick_d = 4'd5;
    else if (snap_q[7] == EMPTY_CODE)   pick_d = 4'd7;
    else                                no_move_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (bus.clr) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:    if (bus.cpu_input_en) state_d = StLoad;
        StLoad:    if (cnt_q == 4'd9) state_d = StEval; else cnt_d = cnt_q + 4'd1;
        StEval:    if (cnt_q == 4'd7) state_d = StPick; else cnt_d = cnt_q + 4'd1;
        StPick:    state_d = StWrite;
        StWrite:   state_d = StDone;
        StDone:    state_d = StWaitLow;
        StWaitLow: if (!bus.cpu_input_en) state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      snap_q     <= '{default: EMPTY_CODE};
      win_vld_q  <= 1'b0;
      blk_vld_q  <= 1'b0;
      win_cell_q <= '0;
      blk_cell_q <= '0;
      pick_q     <= '0;
      no_move_q  <= 1'b0;
    end else if (bus.clr) begin
      cnt_q      <= '0;
      snap_q     <= '{default: EMPTY_CODE};
      win_vld_q  <= 1'b0;
      blk_vld_q  <= 1'b0;
      win_cell_q <= '0;
      blk_cell_q <= '0;
      pick_q     <= '0;
      no_move_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (state_q == StLoad) begin
        // rd_data lags rd_addr by one cycle, so step k carries cell k-1.
        if (cnt_q == 4'd0) begin
          win_vld_q <= 1'b0;
          blk_vld_q <= 1'b0;
        end else begin
          snap_q[cnt_q - 4'd1] <= bus.rd_data;
        end
      end
      if (state_q == StEval && n_empty == 2'd1) begin
        if (n_cpu == 2'd2 && !win_vld_q) begin
          win_vld_q  <= 1'b1;
          win_cell_q <= line_empty;
        end
        if (n_player == 2'd2 && !blk_vld_q) begin
          blk_vld_q  <= 1'b1;
          blk_cell_q <= line_empty;
        end
      end
      if (state_q == StPick) begin
        pick_q    <= pick_d;
        no_move_q <= no_move_d;
      end
    end
  end

  always_comb begin
    bus.rd_addr  = '0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.cpu_done = 1'b0;
    bus.no_move  = 1'b0;
    bus.busy     = (state_q != StIdle) && (state_q != StWaitLow);
    case (state_q)
      StLoad:  if (cnt_q <= 4'd8) bus.rd_addr = cnt_q;
      StWrite: begin
        bus.wr_en   = !no_move_q && !bus.clr;
        bus.wr_addr = pick_q;
        bus.wr_data = CPU_CODE;
      end
      StDone: begin
        bus.cpu_done = !bus.clr;
        bus.no_move  = no_move_q && !bus.clr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_move_engine.sv
// Bench for cpu_move_engine: board RAM with 1-cycle read latency, a
// cycle-since-grant reference model, directed game positions and random play.
module tb_cpu_move_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_move_engine_if bus ();

  cpu_move_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Board store.
  logic [1:0] board [16];
  logic [1:0] load_val [9];
  logic       load_req = 1'b0;

  always @(posedge clk) begin
    bus.rd_data <= board[bus.rd_addr];
    if (load_req) begin
      for (int i = 0; i < 9; i++) board[i] <= load_val[i];
    end else if (bus.wr_en) begin
      board[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Reference move from the game rules, returns {no_move, cell}.
  int lines [8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                       '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};

  function automatic logic [4:0] ref_move();
    int order [8] = '{0, 2, 6, 8, 1, 3, 5, 7};
    int win = -1;
    int blk = -1;
    for (int l = 0; l < 8; l++) begin
      int nc = 0, np = 0, ne = 0, ec = 0;
      for (int j = 0; j < 3; j++) begin
        case (board[lines[l][j]])
          2'b10: nc++;
          2'b01: np++;
          2'b00: begin ne++; ec = lines[l][j]; end
          default: ;
        endcase
      end
      if (nc == 2 && ne == 1 && win < 0) win = ec;
      if (np == 2 && ne == 1 && blk < 0) blk = ec;
    end
    if (win >= 0) return {1'b0, 4'(win)};
    if (blk >= 0) return {1'b0, 4'(blk)};
    if (board[4] == 2'b00) return {1'b0, 4'd4};
    for (int i = 0; i < 8; i++) if (board[order[i]] == 2'b00) return {1'b0, 4'(order[i])};
    return {1'b1, 4'd0};
  endfunction

  // Model: phase = cycles since the grant edge (0 idle, 22 waiting for low).
  int         phase = 0;
  logic [4:0] exp_mv = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) phase <= 0;
    else if (bus.clr) phase <= 0;
    else if (phase == 0) begin
      if (bus.cpu_input_en) begin
        phase  <= 1;
        exp_mv <= ref_move();
      end
    end else if (phase < 22) phase <= phase + 1;
    else if (!bus.cpu_input_en) phase <= 0;
  end

  int         wr_count = 0;
  int         done_count = 0;
  logic [3:0] last_wr_addr = '0;
  logic       last_no_move = 1'b0;

  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      int   p;
      logic exp_wr;
      p      = phase;
      exp_wr = (p == 20) && !exp_mv[4] && !bus.clr;
      check("busy", bus.busy, (p >= 1 && p <= 21) ? 1 : 0);
      check("rd_addr", bus.rd_addr, (p >= 1 && p <= 9) ? p - 1 : 0);
      check("wr_en", bus.wr_en, exp_wr);
      if (exp_wr) begin
        check("wr_addr", bus.wr_addr, exp_mv[3:0]);
        check("wr_data", bus.wr_data, 2'b10);
      end else if (p != 20) begin
        check("wr_addr_idle", bus.wr_addr, 0);
        check("wr_data_idle", bus.wr_data, 0);
      end
      check("cpu_done", bus.cpu_done, (p == 21 && !bus.clr) ? 1 : 0);
      check("no_move", bus.no_move, (p == 21 && !bus.clr) ? exp_mv[4] : 1'b0);
      if (bus.wr_en) begin
        wr_count++;
        last_wr_addr = bus.wr_addr;
      end
      if (bus.cpu_done) begin
        done_count++;
        last_no_move = bus.no_move;
      end
    end
  end

  task automatic load_mask(input logic [8:0] cm, input logic [8:0] pm);
    for (int i = 0; i < 9; i++) load_val[i] = cm[i] ? 2'b10 : (pm[i] ? 2'b01 : 2'b00);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic run_move(input string name, input logic [8:0] cm, input logic [8:0] pm,
                          input logic [3:0] ea, input logic nm);
    int wr0, d0;
    load_mask(cm, pm);
    check({name, "_model"}, ref_move(), {nm, ea});
    wr0 = wr_count;
    d0  = done_count;
    bus.cpu_input_en = 1'b1;
    for (int i = 0; i < 40 && done_count == d0; i++) @(negedge clk);
    bus.cpu_input_en = 1'b0;
    repeat (3) @(negedge clk);
    check({name, "_done"}, done_count - d0, 1);
    check({name, "_writes"}, wr_count - wr0, nm ? 0 : 1);
    check({name, "_no_move"}, last_no_move, nm);
    if (!nm) check({name, "_wr_addr"}, last_wr_addr, ea);
  endtask

  task automatic settle();
    for (int i = 0; i < 40 && phase != 0; i++) @(negedge clk);
    @(negedge clk);
    check("settle_busy", bus.busy, 0);
  endtask

  initial begin
    int wr0, d0;
    bus.clr = 1'b0;
    bus.cpu_input_en = 1'b0;
    #12;
    check("rst_busy", bus.busy, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_cpu_done", bus.cpu_done, 0);
    check("rst_no_move", bus.no_move, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_move("empty", 9'b000000000, 9'b000000000, 4'd4, 1'b0);
    run_move("win_over_block", 9'b000000011, 9'b000011000, 4'd2, 1'b0);
    run_move("block_diag", 9'b000000100, 9'b000010001, 4'd8, 1'b0);
    run_move("corner", 9'b000000000, 9'b000010000, 4'd0, 1'b0);
    run_move("edge", 9'b100000001, 9'b001010100, 4'd1, 1'b0);
    run_move("full", 9'b101010101, 9'b010101010, 4'd0, 1'b1);

    // Abort mid-EVAL.
    load_mask(9'b0, 9'b0);
    wr0 = wr_count;
    d0  = done_count;
    bus.cpu_input_en = 1'b1;
    repeat (14) @(negedge clk);
    bus.clr = 1'b1;
    bus.cpu_input_en = 1'b0;
    @(negedge clk);
    bus.clr = 1'b0;
    #2;
    check("abort_busy", bus.busy, 0);
    repeat (25) @(negedge clk);
    check("abort_writes", wr_count - wr0, 0);
    check("abort_done", done_count - d0, 0);

    // Held enable must not start a second move; re-arm after one low cycle.
    load_mask(9'b0, 9'b0);
    d0 = done_count;
    bus.cpu_input_en = 1'b1;
    for (int i = 0; i < 40 && done_count == d0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("hold_done", done_count - d0, 1);
    check("hold_busy", bus.busy, 0);
    bus.cpu_input_en = 1'b0;
    @(negedge clk);
    bus.cpu_input_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rearm_busy", bus.busy, 1);
    for (int i = 0; i < 40 && done_count == d0 + 1; i++) @(negedge clk);
    bus.cpu_input_en = 1'b0;
    repeat (2) @(negedge clk);
    check("rearm_done", done_count - d0, 2);
    check("rearm_wr_addr", last_wr_addr, 0);
    settle();

    // Random boards, random enable drops, holds and aborts.
    for (int t = 0; t < 40; t++) begin
      int hold, drop_at, clr_at;
      for (int i = 0; i < 9; i++) begin
        int r;
        r = $urandom_range(0, 7);
        load_val[i] = (r < 3) ? 2'b00 : (r < 5) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
      end
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
      hold    = $urandom_range(0, 6);
      drop_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
      clr_at  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 24) : 0;
      bus.cpu_input_en = 1'b1;
      for (int c = 1; c <= 30; c++) begin
        @(negedge clk);
        bus.clr = (c == clr_at);
        if (c == drop_at || c == clr_at || c == 22 + hold) bus.cpu_input_en = 1'b0;
      end
      bus.clr = 1'b0;
      bus.cpu_input_en = 1'b0;
      settle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
